seq_alu: RTL and testbench

Parametrised, multi-cycle successor to the single-cycle combinational ALU. Adds width parametrisation, an iterative shifter, an iterative shift-add multiplier and a valid/ready handshake on both sides. One operation is in flight at a time. Operands and results are registered. Sits between the register-file read stage and writeback in the next-generation datapath.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_logic_unit.sv | 41 ++++
 rtl/seq_alu.sv | 169 ++++++++++++++++
 tb/tb_seq_alu.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU: operation classes, logic functions
// and controller states.
package alu_pkg;

   typedef enum logic [1:0] {
      ARITH = 2'b00,
      LOGIC = 2'b01,
      SHIFT = 2'b10,
      MUL   = 2'b11
   } fnclass_e;

   typedef enum logic [2:0] {
      LF_AND  = 3'b000,
      LF_OR   = 3'b001,
      LF_XOR  = 3'b010,
      LF_NOR  = 3'b011,
      LF_NOTX = 3'b100,
      LF_PASSY = 3'b101,
      LF_ANDN = 3'b110,
      LF_XNOR = 3'b111
   } logicfn_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      EXEC = 2'b01,
      DONE = 2'b10
   } state_e;

endpackage

// File: rtl/alu_logic_unit.sv
// Single-cycle add/sub and bitwise unit; subtraction is x + ~y + 1 so the
// carry-out reads as "no borrow".
module alu_logic_unit
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             arith,
   input  logic             fn,
   input  logic [2:0]       logicfn,
   output logic [WIDTH-1:0] res,
   output logic             cout
);

   logic [WIDTH:0] sum;

   always_comb begin
      sum  = {1'b0, x} + {1'b0, (fn ? ~y : y)} + {{WIDTH{1'b0}}, fn};
      res  = '0;
      cout = 1'b0;
      if (arith) begin
         res  = sum[WIDTH-1:0];
         cout = sum[WIDTH];
      end else begin
         case (logicfn_e'(logicfn))
            LF_AND:   res = x & y;
            LF_OR:    res = x | y;
            LF_XOR:   res = x ^ y;
            LF_NOR:   res = ~(x | y);
            LF_NOTX:  res = ~x;
            LF_PASSY: res = y;
            LF_ANDN:  res = x & ~y;
            LF_XNOR:  res = ~(x ^ y);
            default:  res = '0;
         endcase
      end
   end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU with valid/ready on both sides: one-cycle arith/logic,
// bit-serial shifter and shift-add multiplier sharing one accumulator.
module seq_alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic [1:0]       fnclass,
   input  logic             fn,
   input  logic [2:0]       logicfn,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] value,
   output logic             carry,
   output logic             zeroflag,
   output logic             msb
);

   localparam int CW = SHW + 1;

   state_e             state, state_d;
   fnclass_e           cls;
   logic               fnr;
   logic [2:0]         lfnr;
   logic [WIDTH-1:0]   xr, yr;
   logic [2*WIDTH-1:0] acc, acc_d;
   logic [CW-1:0]      cnt, cnt_d;

   logic               load, res_we, cry_d;
   logic [WIDTH-1:0]   res_d, alu_res, wlo, sh;
   logic               alu_cry, sout;
   logic [WIDTH:0]     psum;
   logic [2*WIDTH-1:0] mul_next;

   alu_logic_unit #(.WIDTH(WIDTH)) u_alu (
      .x       (xr),
      .y       (yr),
      .arith   (cls == ARITH),
      .fn      (fnr),
      .logicfn (lfnr),
      .res     (alu_res),
      .cout    (alu_cry)
   );

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_d;
   end

   always_comb begin
      state_d = state;
      load    = 1'b0;
      res_we  = 1'b0;
      res_d   = '0;
      cry_d   = 1'b0;
      acc_d   = acc;
      cnt_d   = cnt;
      wlo     = acc[WIDTH-1:0];
      // Right shifts fill from the current MSB, which always equals x's MSB.
      if (lfnr[0]) begin
         sh   = {fnr & wlo[WIDTH-1], wlo[WIDTH-1:1]};
         sout = wlo[0];
      end else begin
         sh   = {wlo[WIDTH-2:0], 1'b0};
         sout = wlo[WIDTH-1];
      end
      psum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, xr} : '0);
      mul_next = {psum, acc[WIDTH-1:1]};

      case (state)
         IDLE: begin
            if (in_valid) begin
               load    = 1'b1;
               state_d = EXEC;
               if (fnclass_e'(fnclass) == MUL) begin
                  acc_d = {{WIDTH{1'b0}}, y};
                  cnt_d = CW'(WIDTH);
               end else begin
                  acc_d = {{WIDTH{1'b0}}, x};
                  cnt_d = {1'b0, y[SHW-1:0]};
               end
            end
         end
         EXEC: begin
            case (cls)
               SHIFT: begin
                  if (cnt == '0) begin
                     res_we  = 1'b1;
                     res_d   = wlo;
                     state_d = DONE;
                  end else begin
                     acc_d = {acc[2*WIDTH-1:WIDTH], sh};
                     cnt_d = cnt - CW'(1);
                     if (cnt == CW'(1)) begin
                        res_we  = 1'b1;
                        res_d   = sh;
                        cry_d   = sout;
                        state_d = DONE;
                     end
                  end
               end
               MUL: begin
                  acc_d = mul_next;
                  cnt_d = cnt - CW'(1);
                  if (cnt == CW'(1)) begin
                     res_we  = 1'b1;
                     res_d   = mul_next[WIDTH-1:0];
                     cry_d   = |mul_next[2*WIDTH-1:WIDTH];
                     state_d = DONE;
                  end
               end
               default: begin
                  res_we  = 1'b1;
                  res_d   = alu_res;
                  cry_d   = alu_cry;
                  state_d = DONE;
               end
            endcase
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cls      <= ARITH;
         fnr      <= 1'b0;
         lfnr     <= '0;
         xr       <= '0;
         yr       <= '0;
         acc      <= '0;
         cnt      <= '0;
         value    <= '0;
         carry    <= 1'b0;
         zeroflag <= 1'b1;
         msb      <= 1'b0;
      end else begin
         if (load) begin
            cls  <= fnclass_e'(fnclass);
            fnr  <= fn;
            lfnr <= logicfn;
            xr   <= x;
            yr   <= y;
         end
         acc <= acc_d;
         cnt <= cnt_d;
         if (res_we) begin
            value    <= res_d;
            carry    <= cry_d;
            zeroflag <= (res_d == '0);
            msb      <= res_d[WIDTH-1];
         end
      end
   end

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu at WIDTH=32: results, flags, latency, handshake
// hold and asynchronous reset abort.
module tb_seq_alu;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [31:0] x, y, value;
   logic [1:0]  fnclass;
   logic        fn;
   logic [2:0]  logicfn;
   logic        carry, zeroflag, msb;

   int n_assert = 0;
   int n_fail   = 0;

   seq_alu #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x         (x),
      .y         (y),
      .fnclass   (fnclass),
      .fn        (fn),
      .logicfn   (logicfn),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .value     (value),
      .carry     (carry),
      .zeroflag  (zeroflag),
      .msb       (msb)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic scramble();
      logic [31:0] r;
      r = $urandom;
      x = $urandom;
      y = $urandom;
      fnclass = r[1:0];
      fn      = r[2];
      logicfn = r[5:3];
   endtask

   // Issues one request and waits for out_valid; latency counts the accept edge as 1.
   task automatic run_op(input string tag, input logic [1:0] c, input logic f,
                         input logic [2:0] lf, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ev, input logic ec, input int elat);
      int lat;
      @(negedge clk);
      chk1({tag, ".in_ready"}, in_ready, 1'b1);
      fnclass  = c;
      fn       = f;
      logicfn  = lf;
      x        = a;
      y        = b;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      scramble();
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk({tag, ".latency"}, 32'(lat), 32'(elat));
      chk1({tag, ".out_valid"}, out_valid, 1'b1);
      chk({tag, ".value"}, value, ev);
      chk1({tag, ".carry"}, carry, ec);
      chk1({tag, ".zeroflag"}, zeroflag, (ev == 32'h0));
      chk1({tag, ".msb"}, msb, ev[31]);
   endtask

   task automatic retire(input string tag);
      @(posedge clk);
      #1;
      chk1({tag, ".ret_in_ready"}, in_ready, 1'b1);
      chk1({tag, ".ret_out_valid"}, out_valid, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      x = '0; y = '0; fnclass = '0; fn = 1'b0; logicfn = '0;
      #2 rst_n = 1'b0;
      #1;
      chk("rst.value", value, 32'h0);
      chk1("rst.carry", carry, 1'b0);
      chk1("rst.zeroflag", zeroflag, 1'b1);
      chk1("rst.msb", msb, 1'b0);
      chk1("rst.out_valid", out_valid, 1'b0);
      chk1("rst.in_ready", in_ready, 1'b1);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;

      run_op("add_wrap", 2'b00, 1'b0, 3'b000, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1, 2);
      retire("add_wrap");
      run_op("add_msb", 2'b00, 1'b0, 3'b000, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 2);
      retire("add_msb");
      run_op("sub_borrow", 2'b00, 1'b1, 3'b000, 32'h1, 32'h2, 32'hFFFF_FFFF, 1'b0, 2);
      retire("sub_borrow");
      run_op("sub_eq", 2'b00, 1'b1, 3'b000, 32'h5, 32'h5, 32'h0, 1'b1, 2);
      retire("sub_eq");
      run_op("xor", 2'b01, 1'b0, 3'b010, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 2);
      retire("xor");
      run_op("nor", 2'b01, 1'b0, 3'b011, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h000F_000F, 1'b0, 2);
      retire("nor");
      run_op("andn", 2'b01, 1'b1, 3'b110, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h00F0_00F0, 1'b0, 2);
      retire("andn");
      run_op("sra4", 2'b10, 1'b1, 3'b001, 32'h8000_0000, 32'h4, 32'hF800_0000, 1'b0, 5);
      retire("sra4");
      run_op("sra1_c", 2'b10, 1'b1, 3'b001, 32'h8000_0001, 32'h1, 32'hC000_0000, 1'b1, 2);
      retire("sra1_c");
      run_op("sll1", 2'b10, 1'b0, 3'b000, 32'h8000_0001, 32'h1, 32'h0000_0002, 1'b1, 2);
      retire("sll1");
      run_op("sll_fn1", 2'b10, 1'b1, 3'b000, 32'h0000_0003, 32'h2, 32'h0000_000C, 1'b0, 3);
      retire("sll_fn1");
      run_op("srl31", 2'b10, 1'b0, 3'b001, 32'h8000_0000, 32'h1F, 32'h0000_0001, 1'b0, 32);
      retire("srl31");
      run_op("shamt0", 2'b10, 1'b0, 3'b001, 32'h1234_5678, 32'h20, 32'h1234_5678, 1'b0, 2);
      retire("shamt0");
      run_op("mul_ovf", 2'b11, 1'b0, 3'b000, 32'h0001_0000, 32'h0001_0000, 32'h0, 1'b1, 33);
      retire("mul_ovf");
      run_op("mul_7x6", 2'b11, 1'b0, 3'b000, 32'h7, 32'h6, 32'd42, 1'b0, 33);
      retire("mul_7x6");

      // Result held for 10 cycles with stray requests.
      out_ready = 1'b0;
      run_op("hold", 2'b00, 1'b0, 3'b000, 32'h8000_0003, 32'h4, 32'h8000_0007, 1'b0, 2);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         in_valid = i[0];
         scramble();
         @(posedge clk);
         #1;
         chk("hold.value", value, 32'h8000_0007);
         chk1("hold.carry", carry, 1'b0);
         chk1("hold.zeroflag", zeroflag, 1'b0);
         chk1("hold.msb", msb, 1'b1);
         chk1("hold.out_valid", out_valid, 1'b1);
         chk1("hold.in_ready", in_ready, 1'b0);
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      retire("hold");

      // Abort a multiply with reset partway through.
      run_op("pre_rst", 2'b11, 1'b0, 3'b000, 32'd11, 32'd3, 32'd33, 1'b0, 33);
      retire("pre_rst");
      @(negedge clk);
      fnclass = 2'b11; x = 32'd3; y = 32'd5; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("abort.value", value, 32'h0);
      chk1("abort.carry", carry, 1'b0);
      chk1("abort.zeroflag", zeroflag, 1'b1);
      chk1("abort.msb", msb, 1'b0);
      chk1("abort.out_valid", out_valid, 1'b0);
      chk1("abort.in_ready", in_ready, 1'b1);
      @(negedge clk) rst_n = 1'b1;
      run_op("post_rst", 2'b11, 1'b0, 3'b000, 32'd9, 32'd9, 32'd81, 1'b0, 33);
      retire("post_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
